// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the bus arbiter
`ifndef ASSERT
`define ASSERT 1'b1
`endif
`ifndef NEGATE
`define NEGATE 1'b0
`endif

package bus_pkg;

    localparam int NMASTER = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } arb_state_t;

    typedef logic [1:0] owner_t;

    function automatic logic [NMASTER-1:0] owner_onehot(input owner_t idx);
        return NMASTER'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_arb4_if.sv
// rtl/bus_arb4_if.sv - request/grant bundle between masters and the arbiter
interface bus_arb4_if;
    import bus_pkg::*;

    logic   req0;
    logic   req1;
    logic   req2;
    logic   req3;
    logic   ack;
    logic   gnt0;
    logic   gnt1;
    logic   gnt2;
    logic   gnt3;
    owner_t owner;
    logic   busy;
    logic   tmo;

    modport master (
        output req0, req1, req2, req3, ack,
        input  gnt0, gnt1, gnt2, gnt3, owner, busy, tmo
    );

    modport slave (
        input  req0, req1, req2, req3, ack,
        output gnt0, gnt1, gnt2, gnt3, owner, busy, tmo
    );

endinterface

// File: rtl/ackor.sv
// rtl/ackor.sv - combines per-master acknowledges into one
module ackor (
    input  logic ack0,
    input  logic ack1,
    input  logic ack2,
    input  logic ack3,
    output logic ack
);

    assign ack = ack0 | ack1 | ack2 | ack3;

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select
module rr_pick
    import bus_pkg::*;
(
    input  logic [NMASTER-1:0] req,
    input  owner_t             last,
    output owner_t             winner,
    output logic               valid
);

    owner_t cand;

    // Walk from the lowest priority up so the highest-priority hit is assigned last.
    always_comb begin
        winner = last;
        valid  = 1'b0;
        cand   = last;
        for (int i = NMASTER; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arb4.sv
// rtl/bus_arb4.sv - four-master round-robin arbiter with release cycle and watchdog
module bus_arb4
    import bus_pkg::*;
#(
    parameter  int TIMEOUT = 16,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    bus_arb4_if.slave  bus
);

    arb_state_t          state;
    arb_state_t          state_nx;
    owner_t              owner_q;
    owner_t              last_q;
    owner_t              winner;
    logic                valid;
    logic [CW-1:0]       wd_q;
    logic [NMASTER-1:0]  gnt_q;
    logic [NMASTER-1:0]  req_v;
    logic                tmo_q;
    logic                rel;
    logic                fire_tmo;

    assign req_v = {bus.req3, bus.req2, bus.req1, bus.req0};

    rr_pick u_pick (
        .req    (req_v),
        .last   (last_q),
        .winner (winner),
        .valid  (valid)
    );

    // In GRANT: ack beats abandon beats watchdog; only the watchdog path pulses tmo.
    always_comb begin
        state_nx = state;
        rel      = 1'b0;
        fire_tmo = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    rel = 1'b1;
                end else if (!req_v[owner_q]) begin
                    rel = 1'b1;
                end else if (wd_q == CW'(TIMEOUT - 1)) begin
                    rel      = 1'b1;
                    fire_tmo = 1'b1;
                end
                if (rel) begin
                    state_nx = RELEASE;
                end
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= '0;
            last_q  <= 2'd3;
            wd_q    <= '0;
            gnt_q   <= {NMASTER{`NEGATE}};
            tmo_q   <= `NEGATE;
        end else begin
            state <= state_nx;
            tmo_q <= fire_tmo;
            if (state == IDLE && valid) begin
                owner_q <= winner;
                gnt_q   <= owner_onehot(winner);
                wd_q    <= '0;
            end else if (state == GRANT) begin
                if (rel) begin
                    gnt_q  <= {NMASTER{`NEGATE}};
                    last_q <= owner_q;
                end else if (wd_q != {CW{1'b1}}) begin
                    wd_q <= wd_q + CW'(1);
                end
            end
        end
    end

    assign bus.gnt0  = gnt_q[0];
    assign bus.gnt1  = gnt_q[1];
    assign bus.gnt2  = gnt_q[2];
    assign bus.gnt3  = gnt_q[3];
    assign bus.owner = owner_q;
    assign bus.busy  = (state != IDLE);
    assign bus.tmo   = tmo_q;

endmodule

// File: tb/tb_bus_arb4.sv
// tb/tb_bus_arb4.sv - self-checking bench for bus_arb4 against a behavioural model
`ifndef ASSERT
`define ASSERT 1'b1
`endif
`ifndef NEGATE
`define NEGATE 1'b0
`endif

module tb_bus_arb4;
    import bus_pkg::*;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ackm = 4'b0000;
    int         errs = 0;
    int         checks = 0;

    bus_arb4_if bus ();

    ackor u_ackor (
        .ack0 (ackm[0]),
        .ack1 (ackm[1]),
        .ack2 (ackm[2]),
        .ack3 (ackm[3]),
        .ack  (bus.ack)
    );

    bus_arb4 #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 granted, 2 dead cycle; m_len counts grant cycles so far.
    int         m_st = 0;
    int         m_owner = 0;
    int         m_last = 3;
    int         m_len = 0;
    bit         m_tmo = 1'b0;
    bit         m_found;
    logic [3:0] m_req;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_owner = 0; m_last = 3; m_len = 0; m_tmo = 1'b0;
        end else begin
            m_req = {bus.req3, bus.req2, bus.req1, bus.req0};
            m_tmo = 1'b0;
            if (m_st == 0) begin
                m_found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!m_found && m_req[(m_last + k) % 4]) begin
                        m_found = 1'b1;
                        m_owner = (m_last + k) % 4;
                    end
                end
                if (m_found) begin
                    m_st = 1;
                    m_len = 1;
                end
            end else if (m_st == 1) begin
                if (bus.ack || !m_req[m_owner] || m_len == TIMEOUT) begin
                    m_tmo  = !bus.ack && m_req[m_owner] && (m_len == TIMEOUT);
                    m_st   = 2;
                    m_last = m_owner;
                end else begin
                    m_len++;
                end
            end else begin
                m_st = 0;
            end
        end
    end

    function automatic logic [3:0] gnt_v();
        return {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic set_req(input logic [3:0] r);
        bus.req0 = r[0];
        bus.req1 = r[1];
        bus.req2 = r[2];
        bus.req3 = r[3];
    endtask

    // Compare against the model mid-cycle, then land 1 unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        chk("model_gnt", int'(gnt_v()), (m_st == 1) ? (1 << m_owner) : 0);
        chk("model_owner", int'(bus.owner), m_owner);
        chk("model_busy", int'(bus.busy), (m_st != 0) ? 1 : 0);
        chk("model_tmo", int'(bus.tmo), int'(m_tmo));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int want, output int n);
        int idx;
        logic [3:0] g;
        idx = -1;
        n = 0;
        while (idx < 0 && n < 24) begin
            tick();
            n++;
            g = gnt_v();
            for (int k = 0; k < 4; k++) begin
                if (g == 4'(1 << k)) idx = k;
            end
        end
        chk("grant_index", idx, want);
    endtask

    task automatic grant_ack(input int idx, input int ncyc, input logic [3:0] req_after);
        repeat (ncyc - 1) tick();
        #1;
        ackm[idx] = `ASSERT;
        set_req(req_after);
        tick();
        chk("release_gnt", int'(gnt_v()), 0);
        chk("release_busy", int'(bus.busy), 1);
        #1;
        ackm = 4'b0000;
    endtask

    task automatic do_reset();
        rst = `ASSERT;
        #1;
        chk("rst_gnt", int'(gnt_v()), 0);
        chk("rst_owner", int'(bus.owner), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_tmo", int'(bus.tmo), 0);
        #2;
        rst = `NEGATE;
    endtask

    int n;
    int hi;
    bit run;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        set_req(4'b0000);
        #1;
        rst = `ASSERT;
        tick();
        tick();
        chk("reset_gnt", int'(gnt_v()), 0);
        chk("reset_owner", int'(bus.owner), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_tmo", int'(bus.tmo), 0);
        #1;
        rst = `NEGATE;
        tick();

        // lone req2, acked in its third grant cycle
        #1;
        set_req(4'b0100);
        wait_gnt(2, n);
        chk("req2_latency", n, 1);
        chk("req2_gnt", int'(gnt_v()), 4'b0100);
        grant_ack(2, 3, 4'b0000);
        tick();
        chk("req2_idle_busy", int'(bus.busy), 0);

        // all four requesting from reset priority, each acked after two grant cycles
        do_reset();
        tick();
        #1;
        set_req(4'b1111);
        for (int i = 0; i < 5; i++) begin
            wait_gnt(order[i], n);
            if (i > 0) chk("rr_gap", n, 2);
            grant_ack(order[i], 2, (i == 4) ? 4'b0000 : 4'b1111);
        end

        // make last=1, then req0+req3 together: 3 first, then 0
        set_req(4'b0010);
        wait_gnt(1, n);
        grant_ack(1, 1, 4'b0000);
        set_req(4'b1001);
        wait_gnt(3, n);
        grant_ack(3, 1, 4'b1001);
        wait_gnt(0, n);
        grant_ack(0, 1, 4'b0000);

        // watchdog on req1
        tick();
        #1;
        set_req(4'b0010);
        wait_gnt(1, n);
        hi = 1;
        run = 1'b1;
        for (int c = 0; c < 40 && run; c++) begin
            tick();
            if (gnt_v() == 4'b0010) hi++;
            else run = 1'b0;
        end
        chk("tmo_gnt_cycles", hi, TIMEOUT);
        chk("tmo_pulse", int'(bus.tmo), 1);
        #1;
        set_req(4'b0111);
        wait_gnt(2, n);
        chk("post_tmo_tmo_low", int'(bus.tmo), 0);
        grant_ack(2, 1, 4'b0000);

        // req0 abandons after two grant cycles
        tick();
        #1;
        set_req(4'b0001);
        wait_gnt(0, n);
        tick();
        #1;
        set_req(4'b0000);
        tick();
        chk("abandon_gnt", int'(gnt_v()), 0);
        chk("abandon_tmo", int'(bus.tmo), 0);
        chk("abandon_busy", int'(bus.busy), 1);
        tick();
        chk("abandon_idle", int'(bus.busy), 0);

        // reset in the middle of a grant, then req0 wins over req1
        #1;
        set_req(4'b0010);
        wait_gnt(1, n);
        do_reset();
        set_req(4'b0011);
        wait_gnt(0, n);
        grant_ack(0, 1, 4'b0000);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
